// File: rtl/async_fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the async FIFO write-port arbiter.
// Optional feature macro used by the top: ASYNC_FIFO_ARB_STATS_EN.
package async_fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  function automatic int id_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_if.sv
// Requester bus plus async_fifo write-side signals shared by the arbiter.
// master = producers/FIFO side, slave = arbiter.
import async_fifo_arb_pkg::*;

interface async_fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic [ID_W+WIDTH-1:0]    fifo_din;
  logic                     fifo_wput;
  logic                     fifo_full;

  modport master (
    output req_data, req_valid, req_last, fifo_full,
    input  req_ready, fifo_din, fifo_wput
  );

  modport slave (
    input  req_data, req_valid, req_last, fifo_full,
    output req_ready, fifo_din, fifo_wput
  );

endinterface

// File: rtl/async_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first valid index at or after
// ptr, wrapping modulo N. Indices >= N are never produced.
import async_fifo_arb_pkg::*;

module rr_pick #(
  parameter int N = 4,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand [N];
  logic [N-1:0]  hit;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      localparam logic [IW:0] OFFSET = (IW+1)'(gi);
      localparam logic [IW:0] LIMIT  = (IW+1)'(N);
      logic [IW:0] sum;
      assign sum       = {1'b0, ptr} + OFFSET;
      assign cand[gi]  = (sum >= LIMIT) ? IW'(sum - LIMIT) : IW'(sum);
      assign hit[gi]   = valid[cand[gi]];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the write port of one async_fifo.
// ASYNC_FIFO_ARB_STATS_EN adds a saturating stall_cnt output.
import async_fifo_arb_pkg::*;

module async_fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4,
  localparam int ID_W     = id_width(NUM_REQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  async_fifo_wr_arbiter_if.slave bus,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy
`ifdef ASYNC_FIFO_ARB_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(NUM_REQ - 1);

  arb_state_t       state_reg, state_next;
  logic [ID_W-1:0]  ptr_reg, ptr_next;
  logic [ID_W-1:0]  grant_reg, grant_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [WIDTH-1:0] data_arr [NUM_REQ];
  logic [WIDTH-1:0] g_data;
  logic             g_valid;
  logic             g_last;
  logic             g_accept;
  logic             in_burst;
  logic [ID_W-1:0]  ptr_after;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign data_arr[gi] = bus.req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_reg),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign g_data    = data_arr[grant_reg];
  assign g_valid   = bus.req_valid[grant_reg];
  assign g_last    = bus.req_last[grant_reg];
  assign g_accept  = g_valid & ~bus.fifo_full;
  // Reset gates the outputs so a beat presented during wrst is never written.
  assign in_burst  = (state_reg == BURST) & ~wrst;
  assign ptr_after = (grant_reg == ID_MAX) ? '0 : grant_reg + 1'b1;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          grant_next = pick_idx;
          cnt_next   = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        // Full stalls the burst in place; only valid-drop, last or the
        // beat limit hand the port on.
        if (!g_valid) begin
          state_next = IDLE;
          ptr_next   = ptr_after;
        end else if (g_accept) begin
          cnt_next = cnt_reg + 1'b1;
          if (g_last || (cnt_reg == CNT_LAST)) begin
            state_next = IDLE;
            ptr_next   = ptr_after;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.fifo_wput = 1'b0;
    bus.fifo_din  = '0;
    if (in_burst) begin
      bus.req_ready[grant_reg] = g_accept;
      bus.fifo_wput            = g_accept;
      bus.fifo_din             = {grant_reg, g_data};
    end
  end

  assign grant_id = grant_reg;
  assign busy     = in_burst;

`ifdef ASYNC_FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      stall_cnt_reg <= '0;
    end else if (in_burst && g_valid && bus.fifo_full && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed-vector bench for async_fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, BURST_MAX=4).
module tb_async_fifo_wr_arbiter;

  logic       wclk;
  logic       wrst;
  logic [1:0] grant_id;
  logic       busy;
`ifdef ASYNC_FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  async_fifo_wr_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

  async_fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .BURST_MAX(4)) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .bus      (bus.slave),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef ASYNC_FIFO_ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample combinational outputs mid-cycle, then advance past the edge.
  task automatic tick(input string tag, input logic e_busy, input logic [1:0] e_gid,
                      input logic e_wput, input logic [3:0] e_ready, input logic [9:0] e_din);
    @(negedge wclk);
    check_val({tag, ".busy"},  32'(busy),          32'(e_busy));
    check_val({tag, ".wput"},  32'(bus.fifo_wput), 32'(e_wput));
    check_val({tag, ".ready"}, 32'(bus.req_ready), 32'(e_ready));
    if (e_busy) check_val({tag, ".gid"}, 32'(grant_id), 32'(e_gid));
    if (e_wput) check_val({tag, ".din"}, 32'(bus.fifo_din), 32'(e_din));
    $display("cycle %s busy=%0b gid=%0d wput=%0b ready=%b din=%h",
             tag, busy, grant_id, bus.fifo_wput, bus.req_ready, bus.fifo_din);
    @(posedge wclk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_id;
    logic [9:0] exp_din;

    // Scenario 1: reset with everyone requesting
    wrst           = 1'b1;
    bus.req_valid  = 4'hF;
    bus.req_last   = 4'h0;
    bus.fifo_full  = 1'b0;
    bus.req_data   = {8'h43, 8'h42, 8'h41, 8'h40};
    @(posedge wclk);
    #1;
    tick("rst0", 1'b0, 2'd0, 1'b0, 4'b0000, 10'h000);
    tick("rst1", 1'b0, 2'd0, 1'b0, 4'b0000, 10'h000);
    check_val("rst.gid", 32'(grant_id), 32'd0);
    wrst = 1'b0;
    tick("s1_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 10'h000);
    tick("s1_beat", 1'b1, 2'd0, 1'b1, 4'b0001, {2'd0, 8'h40});
    bus.req_valid = 4'h0;
    tick("s1_drop", 1'b1, 2'd0, 1'b0, 4'b0000, 10'h000);

    // Scenario 2: req2 alone, three beats, last on the third (ptr=1 -> picks 2)
    bus.req_valid = 4'b0100;
    tick("s2_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 10'h000);
    bus.req_data[16 +: 8] = 8'hA1;
    tick("s2_b1", 1'b1, 2'd2, 1'b1, 4'b0100, {2'd2, 8'hA1});
    bus.req_data[16 +: 8] = 8'hA2;
    tick("s2_b2", 1'b1, 2'd2, 1'b1, 4'b0100, {2'd2, 8'hA2});
    bus.req_data[16 +: 8] = 8'hA3;
    bus.req_last  = 4'b0100;
    tick("s2_b3", 1'b1, 2'd2, 1'b1, 4'b0100, {2'd2, 8'hA3});

    // Scenario 5: ptr=3 so req3 wins over req0, then abandons after one beat
    bus.req_last  = 4'b0000;
    bus.req_valid = 4'b1001;
    bus.req_data[24 +: 8] = 8'hB0;
    bus.req_data[0 +: 8]  = 8'h50;
    tick("s5_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 10'h000);
    tick("s5_b1", 1'b1, 2'd3, 1'b1, 4'b1000, {2'd3, 8'hB0});
    bus.req_valid = 4'b0001;
    tick("s5_drop", 1'b1, 2'd3, 1'b0, 4'b0000, 10'h000);
    tick("s5_idle2", 1'b0, 2'd0, 1'b0, 4'b0000, 10'h000);
    bus.req_last  = 4'b0001;
    tick("s5_g0", 1'b1, 2'd0, 1'b1, 4'b0001, {2'd0, 8'h50});

    // Scenario 6: reset during beat 2 of req1's burst
    bus.req_last  = 4'b0000;
    bus.req_valid = 4'b0010;
    bus.req_data[8 +: 8] = 8'h61;
    tick("s6_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 10'h000);
    tick("s6_b1", 1'b1, 2'd1, 1'b1, 4'b0010, {2'd1, 8'h61});
    bus.req_data[8 +: 8] = 8'h62;
    wrst = 1'b1;
    tick("s6_rst", 1'b0, 2'd0, 1'b0, 4'b0000, 10'h000);
    wrst = 1'b0;
`ifdef ASYNC_FIFO_ARB_STATS_EN
    check_val("s6.stall", 32'(stall_cnt), 32'd0);
`endif

    // Scenario 3: all valid, never last -> 0,1,2,3,0 with four beats each
    bus.req_valid = 4'hF;
    bus.req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    for (int b = 0; b < 5; b++) begin
      exp_id  = 2'(b % 4);
      exp_din = {exp_id, 8'hC0 + {6'd0, exp_id}};
      tick($sformatf("s3_idle%0d", b), 1'b0, 2'd0, 1'b0, 4'b0000, 10'h000);
      for (int k = 0; k < 4; k++) begin
        tick($sformatf("s3_g%0d_b%0d", b, k), 1'b1, exp_id, 1'b1, 4'b0001 << exp_id, exp_din);
      end
    end

    // Scenario 4: req1 stalled by full for five cycles after beat 2
    bus.req_valid = 4'b0010;
    bus.req_data[8 +: 8] = 8'h71;
    tick("s4_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 10'h000);
    tick("s4_b1", 1'b1, 2'd1, 1'b1, 4'b0010, {2'd1, 8'h71});
    bus.req_data[8 +: 8] = 8'h72;
    tick("s4_b2", 1'b1, 2'd1, 1'b1, 4'b0010, {2'd1, 8'h72});
    bus.req_data[8 +: 8] = 8'h73;
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick($sformatf("s4_full%0d", k), 1'b1, 2'd1, 1'b0, 4'b0000, 10'h000);
    end
    bus.fifo_full = 1'b0;
    tick("s4_b3", 1'b1, 2'd1, 1'b1, 4'b0010, {2'd1, 8'h73});
    bus.req_data[8 +: 8] = 8'h74;
    tick("s4_b4", 1'b1, 2'd1, 1'b1, 4'b0010, {2'd1, 8'h74});
    bus.req_valid = 4'b0000;
    tick("s4_end", 1'b0, 2'd0, 1'b0, 4'b0000, 10'h000);
`ifdef ASYNC_FIFO_ARB_STATS_EN
    check_val("s4.stall", 32'(stall_cnt), 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
